// File: rtl/branch_direction_predictor.sv
// ---------------------------------------------------------------------------
// branch_direction_predictor
//
// Gshare direction predictor for the dual-issue fetch front end. A table of
// 2-bit saturating counters is indexed by (slot_pc[INDEX_BITS+1:2] ^ GHR).
// The prediction for the selected slot is combinational from the current
// state and feeds the PC control unit in the same cycle.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   pc                     fetch-pair PC (slot1 = pc, slot2 = pc + 4)
//   is_branch1/is_branch2  per-slot conditional-branch decode
//   stall, nop2            front end frozen / fetch pair is a bubble
//   branch_predict_result  predicted-taken for the selected slot
//   pred_ghr               GHR used for this cycle's prediction
//   update_*               training from a resolved branch in execute
//   recover_*              GHR repair on misprediction flush
// ---------------------------------------------------------------------------
module branch_direction_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int GHR_BITS   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         pc,
    input  logic                is_branch1,
    input  logic                is_branch2,
    input  logic                stall,
    input  logic                nop2,
    output logic                branch_predict_result,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                update_en,
    input  logic [31:0]         update_pc,
    input  logic [GHR_BITS-1:0] update_ghr,
    input  logic                update_taken,
    input  logic                recover_en,
    input  logic [GHR_BITS-1:0] recover_ghr,
    input  logic                recover_taken
);

    localparam int DEPTH = 1 << INDEX_BITS;

    // Register array (not SRAM) so the asynchronous reset reaches every entry.
    logic [1:0]            ctr_q [DEPTH];
    logic [GHR_BITS-1:0]   ghr_q;

    logic [31:0]           pc2;
    logic [INDEX_BITS-1:0] ghr_ext;
    logic [INDEX_BITS-1:0] upd_ghr_ext;
    logic [INDEX_BITS-1:0] idx1;
    logic [INDEX_BITS-1:0] idx2;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [1:0]            upd_cur;
    logic [1:0]            upd_next;
    logic                  pred;
    logic                  advance;

    // Slot2 address wraps at 32 bits.
    assign pc2         = pc + 32'd4;
    assign ghr_ext     = INDEX_BITS'(ghr_q);
    assign upd_ghr_ext = INDEX_BITS'(update_ghr);
    assign idx1        = pc[INDEX_BITS+1:2] ^ ghr_ext;
    assign idx2        = pc2[INDEX_BITS+1:2] ^ ghr_ext;
    assign upd_idx     = update_pc[INDEX_BITS+1:2] ^ upd_ghr_ext;

    // Slot selection mirrors the PC control unit: slot1 branch wins.
    always_comb begin
        pred = 1'b0;
        if (is_branch1) begin
            pred = ctr_q[idx1][1];
        end else if (is_branch2) begin
            pred = ctr_q[idx2][1];
        end
    end

    assign branch_predict_result = pred;
    assign pred_ghr              = ghr_q;
    assign advance               = !stall && !nop2;

    // Recovery outranks the speculative shift; at most one history bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else if (recover_en) begin
            ghr_q <= {recover_ghr[GHR_BITS-2:0], recover_taken};
        end else if (advance && (is_branch1 || is_branch2)) begin
            ghr_q <= {ghr_q[GHR_BITS-2:0], pred};
        end
    end

    // Saturating step for the trained entry.
    assign upd_cur = ctr_q[upd_idx];

    always_comb begin
        upd_next = upd_cur;
        if (update_taken) begin
            if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
        end else begin
            if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
        end
    end

    // Training is independent of stall/nop2/recover. A same-cycle read of the
    // trained entry sees the old value; the new one is visible next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (update_en) begin
            ctr_q[upd_idx] <= upd_next;
        end
    end

    // Address bits outside the index field carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{pc2[31:INDEX_BITS+2], pc2[1:0],
                           update_pc[31:INDEX_BITS+2], update_pc[1:0]};

endmodule

// File: tb/tb_branch_direction_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_direction_predictor
//
// Directed bench for the gshare predictor. Each task drives one scenario and
// compares outputs against hand-computed values. Indices with GHR=0:
// 0x80000000 -> 0, 0x80000004 -> 1, 0x80000008 -> 2, 0x8000000C -> 3.
// ---------------------------------------------------------------------------
module tb_branch_direction_predictor;

  localparam int INDEX_BITS = 6;
  localparam int GHR_BITS   = 6;

  logic                clk;
  logic                rst_n;
  logic [31:0]         pc;
  logic                is_branch1;
  logic                is_branch2;
  logic                stall;
  logic                nop2;
  logic                branch_predict_result;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                update_en;
  logic [31:0]         update_pc;
  logic [GHR_BITS-1:0] update_ghr;
  logic                update_taken;
  logic                recover_en;
  logic [GHR_BITS-1:0] recover_ghr;
  logic                recover_taken;

  int vec_cnt;
  int err_cnt;

  branch_direction_predictor #(
    .INDEX_BITS(INDEX_BITS),
    .GHR_BITS  (GHR_BITS)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pc                   (pc),
    .is_branch1           (is_branch1),
    .is_branch2           (is_branch2),
    .stall                (stall),
    .nop2                 (nop2),
    .branch_predict_result(branch_predict_result),
    .pred_ghr             (pred_ghr),
    .update_en            (update_en),
    .update_pc            (update_pc),
    .update_ghr           (update_ghr),
    .update_taken         (update_taken),
    .recover_en           (recover_en),
    .recover_ghr          (recover_ghr),
    .recover_taken        (recover_taken)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    pc            = 32'h0;
    is_branch1    = 1'b0;
    is_branch2    = 1'b0;
    stall         = 1'b0;
    nop2          = 1'b0;
    update_en     = 1'b0;
    update_pc     = 32'h0;
    update_ghr    = '0;
    update_taken  = 1'b0;
    recover_en    = 1'b0;
    recover_ghr   = '0;
    recover_taken = 1'b0;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_update(input logic [31:0] upc, input logic [GHR_BITS-1:0] ug,
                              input logic tk);
    update_en    = 1'b1;
    update_pc    = upc;
    update_ghr   = ug;
    update_taken = tk;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n      = 1'b0;
    pc         = 32'h8000_0000;
    is_branch1 = 1'b1;
    #1;
    vec_cnt++;
    if (branch_predict_result !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_pred: got %b expected %b", branch_predict_result, 1'b0);
    end
    vec_cnt++;
    if (pred_ghr !== 6'b000000) begin
      err_cnt++;
      $display("FAIL reset_ghr: got %b expected %b", pred_ghr, 6'b000000);
    end
    clk_edge();
    rst_n = 1'b1;
    // One advancing cycle predicting 0 shifts a 0 into GHR.
    clk_edge();
    vec_cnt++;
    if (pred_ghr !== 6'b000000) begin
      err_cnt++;
      $display("FAIL reset_advance_ghr: got %b expected %b", pred_ghr, 6'b000000);
    end
  endtask

  task automatic test_train_saturate();
    logic exp_seq [5];
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    // Freeze GHR at 0 while training index 0.
    stall      = 1'b1;
    pc         = 32'h8000_0000;
    is_branch1 = 1'b1;
    drive_update(32'h8000_0000, 6'd0, 1'b1);
    #1;
    vec_cnt++;
    if (branch_predict_result !== 1'b0) begin
      err_cnt++;
      $display("FAIL train_pre: got %b expected %b", branch_predict_result, 1'b0);
    end
    // taken x3: 01->10->11->11, then not-taken x2: 11->10->01
    for (int i = 0; i < 5; i++) begin
      update_taken = (i < 3);
      clk_edge();
      vec_cnt++;
      if (branch_predict_result !== exp_seq[i]) begin
        err_cnt++;
        $display("FAIL train_step%0d: got %b expected %b", i, branch_predict_result, exp_seq[i]);
      end
    end
    // Low saturation on index 2: 01->00->00, then taken ->01 (predict 0), taken ->10 (predict 1)
    pc = 32'h8000_0008;
    drive_update(32'h8000_0008, 6'd0, 1'b0);
    clk_edge();
    clk_edge();
    update_taken = 1'b1;
    clk_edge();
    vec_cnt++;
    if (branch_predict_result !== 1'b0) begin
      err_cnt++;
      $display("FAIL low_sat_01: got %b expected %b", branch_predict_result, 1'b0);
    end
    clk_edge();
    update_en = 1'b0;
    vec_cnt++;
    if (branch_predict_result !== 1'b1) begin
      err_cnt++;
      $display("FAIL low_sat_10: got %b expected %b", branch_predict_result, 1'b1);
    end
  endtask

  task automatic test_slot2();
    pc         = 32'h8000_0000;
    is_branch1 = 1'b0;
    is_branch2 = 1'b1;
    #1;
    vec_cnt++;
    if (branch_predict_result !== 1'b0) begin
      err_cnt++;
      $display("FAIL slot2_pre: got %b expected %b", branch_predict_result, 1'b0);
    end
    drive_update(32'h8000_0004, 6'd0, 1'b1);
    clk_edge();
    clk_edge();
    update_en = 1'b0;
    vec_cnt++;
    if (branch_predict_result !== 1'b1) begin
      err_cnt++;
      $display("FAIL slot2_trained: got %b expected %b", branch_predict_result, 1'b1);
    end
    is_branch1 = 1'b1;
    is_branch2 = 1'b0;
    #1;
    vec_cnt++;
    if (branch_predict_result !== 1'b0) begin
      err_cnt++;
      $display("FAIL slot1_untouched: got %b expected %b", branch_predict_result, 1'b0);
    end
  endtask

  task automatic test_history();
    // Counters: idx0=01, idx1=11, idx2=10, idx3=01, others 01.
    stall      = 1'b0;
    nop2       = 1'b0;
    is_branch1 = 1'b1;
    is_branch2 = 1'b0;
    pc         = 32'h8000_0004;     // idx 1^0 = 1 -> 11
    #1;
    vec_cnt++;
    if (branch_predict_result !== 1'b1) begin
      err_cnt++;
      $display("FAIL hist_pred0: got %b expected %b", branch_predict_result, 1'b1);
    end
    clk_edge();
    vec_cnt++;
    if (pred_ghr !== 6'b000001) begin
      err_cnt++;
      $display("FAIL hist_ghr0: got %b expected %b", pred_ghr, 6'b000001);
    end
    // idx 1^1 = 0 -> 01
    vec_cnt++;
    if (branch_predict_result !== 1'b0) begin
      err_cnt++;
      $display("FAIL hist_pred1: got %b expected %b", branch_predict_result, 1'b0);
    end
    clk_edge();
    pc = 32'h8000_000C;             // idx 3^2 = 1 -> 11
    #1;
    vec_cnt++;
    if (branch_predict_result !== 1'b1) begin
      err_cnt++;
      $display("FAIL hist_pred2: got %b expected %b", branch_predict_result, 1'b1);
    end
    clk_edge();
    vec_cnt++;
    if (pred_ghr !== 6'b000101) begin
      err_cnt++;
      $display("FAIL hist_ghr2: got %b expected %b", pred_ghr, 6'b000101);
    end
    stall = 1'b1;
    clk_edge();
    vec_cnt++;
    if (pred_ghr !== 6'b000101) begin
      err_cnt++;
      $display("FAIL hist_stall: got %b expected %b", pred_ghr, 6'b000101);
    end
    stall = 1'b0;
    nop2  = 1'b1;
    clk_edge();
    vec_cnt++;
    if (pred_ghr !== 6'b000101) begin
      err_cnt++;
      $display("FAIL hist_nop2: got %b expected %b", pred_ghr, 6'b000101);
    end
    nop2       = 1'b0;
    is_branch1 = 1'b0;
    clk_edge();
    vec_cnt++;
    if (pred_ghr !== 6'b000101) begin
      err_cnt++;
      $display("FAIL hist_nobranch: got %b expected %b", pred_ghr, 6'b000101);
    end
  endtask

  task automatic test_recover();
    recover_en    = 1'b1;
    recover_ghr   = 6'b000011;
    recover_taken = 1'b0;
    stall         = 1'b0;
    nop2          = 1'b0;
    is_branch1    = 1'b1;
    pc            = 32'h8000_0004;
    clk_edge();
    recover_en = 1'b0;
    vec_cnt++;
    if (pred_ghr !== 6'b000110) begin
      err_cnt++;
      $display("FAIL recover_ghr: got %b expected %b", pred_ghr, 6'b000110);
    end
  endtask

  task automatic test_collision();
    // GHR=6 frozen; pc 0x80000000 -> idx 6, counter 01.
    stall      = 1'b1;
    is_branch1 = 1'b1;
    pc         = 32'h8000_0000;
    drive_update(32'h8000_0000, 6'b000110, 1'b1);
    #1;
    vec_cnt++;
    if (branch_predict_result !== 1'b0) begin
      err_cnt++;
      $display("FAIL collide_same: got %b expected %b", branch_predict_result, 1'b0);
    end
    clk_edge();
    update_en = 1'b0;
    vec_cnt++;
    if (branch_predict_result !== 1'b1) begin
      err_cnt++;
      $display("FAIL collide_next: got %b expected %b", branch_predict_result, 1'b1);
    end
  endtask

  task automatic test_wrap_priority();
    // pc 0xFFFFFFFC: slot1 idx 0x3F^6=0x39 (01), slot2 wraps to 0 -> idx 6 (10)
    pc         = 32'hFFFF_FFFC;
    is_branch1 = 1'b0;
    is_branch2 = 1'b1;
    #1;
    vec_cnt++;
    if (branch_predict_result !== 1'b1) begin
      err_cnt++;
      $display("FAIL wrap_slot2: got %b expected %b", branch_predict_result, 1'b1);
    end
    is_branch1 = 1'b1;
    #1;
    vec_cnt++;
    if (branch_predict_result !== 1'b0) begin
      err_cnt++;
      $display("FAIL both_slot1_wins: got %b expected %b", branch_predict_result, 1'b0);
    end
    is_branch1 = 1'b0;
    is_branch2 = 1'b0;
    #1;
    vec_cnt++;
    if (branch_predict_result !== 1'b0) begin
      err_cnt++;
      $display("FAIL no_branch: got %b expected %b", branch_predict_result, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    pc         = 32'h8000_0000;     // idx 6 -> 10
    is_branch1 = 1'b1;
    #1;
    vec_cnt++;
    if (branch_predict_result !== 1'b1) begin
      err_cnt++;
      $display("FAIL areset_pre: got %b expected %b", branch_predict_result, 1'b1);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (branch_predict_result !== 1'b0) begin
      err_cnt++;
      $display("FAIL areset_pred: got %b expected %b", branch_predict_result, 1'b0);
    end
    vec_cnt++;
    if (pred_ghr !== 6'b000000) begin
      err_cnt++;
      $display("FAIL areset_ghr: got %b expected %b", pred_ghr, 6'b000000);
    end
    pc = 32'h8000_0004;             // idx1 was 11, now 01
    #1;
    vec_cnt++;
    if (branch_predict_result !== 1'b0) begin
      err_cnt++;
      $display("FAIL areset_idx1: got %b expected %b", branch_predict_result, 1'b0);
    end
    is_branch1 = 1'b0;
    is_branch2 = 1'b1;              // idx2 was 10, now 01
    #1;
    vec_cnt++;
    if (branch_predict_result !== 1'b0) begin
      err_cnt++;
      $display("FAIL areset_idx2: got %b expected %b", branch_predict_result, 1'b0);
    end
    clk_edge();
    rst_n      = 1'b1;
    stall      = 1'b0;
    is_branch1 = 1'b1;
    is_branch2 = 1'b0;
    pc         = 32'h8000_0000;
    clk_edge();
    vec_cnt++;
    if (pred_ghr !== 6'b000000) begin
      err_cnt++;
      $display("FAIL post_reset_ghr: got %b expected %b", pred_ghr, 6'b000000);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_train_saturate();
    test_slot2();
    test_history();
    test_recover();
    test_collision();
    test_wrap_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
